// File: rtl/uart_tx_fifo_if.sv
// Controller-side handshake and status bundle for uart_tx_fifo, plus the serial TX line.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int LEVEL_W   = 5
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_data_request;
    logic                 tx_ready;
    logic                 tx_overflow;
    logic [LEVEL_W-1:0]   fifo_level;
    logic                 tx_busy;
    logic                 uart_tx;

    modport master (
        output tx_data, tx_data_request,
        input  tx_ready, tx_overflow, fifo_level, tx_busy, uart_tx
    );

    modport slave (
        input  tx_data, tx_data_request,
        output tx_ready, tx_overflow, fifo_level, tx_busy, uart_tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with FIFO: a word accepted into an idle empty block drives the start bit one cycle later.
// Writes are refused (tx_ready low, overflow pulse) while full; queued frames go out back-to-back.
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          i_master_clk,
    input  logic          i_reset,
    uart_tx_fifo_if.slave bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int LEVEL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int TMR_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic               STOP_LAST = (STOP_BITS == 2);
    localparam logic [LEVEL_W-1:0] FULL_LVL  = LEVEL_W'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_err_baud
        $error("uart_tx_fifo: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_n;
    logic [TMR_W-1:0]     timer;
    logic [BIT_W-1:0]     bit_idx, bit_idx_n;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 line, line_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0]   level, level_n;
    logic                 ready, overflow, busy, busy_n;
    logic                 push, pop, tick, parity_bit;

    assign push       = bus.tx_data_request && ready;
    assign tick       = (timer == TMR_LAST);
    assign parity_bit = (^shift) ^ (PARITY == 1);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START:  if (tick) state_n = S_DATA;
            S_DATA: begin
                if (tick && bit_idx == BIT_LAST)
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tick) state_n = S_STOP;
            S_STOP: begin
                // Reload straight into START when more data waits: no idle gap between frames.
                if (tick && stop_idx == STOP_LAST) begin
                    if (level != '0) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bit_idx_n = '0;
        if (state == S_DATA)
            bit_idx_n = tick ? bit_idx + 1'b1 : bit_idx;
        case (state_n)
            S_START:  line_n = 1'b0;
            S_DATA:   line_n = shift[bit_idx_n];
            S_PARITY: line_n = parity_bit;
            default:  line_n = 1'b1;
        endcase
    end

    always_comb begin
        level_n = level;
        if (push && !pop)
            level_n = level + 1'b1;
        else if (pop && !push)
            level_n = level - 1'b1;
        busy_n = (state_n != S_IDLE) || (level_n != '0);
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            line     <= 1'b1;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_idx_n;
            line     <= line_n;
            timer    <= (state == S_IDLE || tick) ? '0 : timer + 1'b1;
            if (state != S_STOP)
                stop_idx <= 1'b0;
            else if (tick)
                stop_idx <= ~stop_idx;
            if (pop)
                shift <= mem[rd_ptr];
        end
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready    <= 1'b1;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level    <= level_n;
            // A slot freed by a pop while full only reopens the write port on the following cycle.
            ready    <= (level_n != FULL_LVL);
            overflow <= bus.tx_data_request && !ready;
            busy     <= busy_n;
        end
    end

    always_ff @(posedge i_master_clk) begin
        if (push)
            mem[wr_ptr] <= bus.tx_data;
    end

    assign bus.tx_ready    = ready;
    assign bus.tx_overflow = overflow;
    assign bus.fifo_level  = level;
    assign bus.tx_busy     = busy;
    assign bus.uart_tx     = line;
endmodule
